// File: rtl/reg_arb.sv
// rtl/reg_arb.sv - two-requester round-robin arbiter in front of a 3-address-bit register file
module reg_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [2:0] addr0,
  input  logic [2:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic [2:0] wa3,
  output logic [7:0] wd3,
  output logic       we3,
  output logic [2:0] ra1,
  input  logic [7:0] rd1
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e     state_q, state_d;
  logic       rr_last_q, rr_last_d;
  logic       cmd_we_q, cmd_we_d;
  logic [2:0] cmd_addr_q, cmd_addr_d;
  logic [7:0] cmd_wdata_q, cmd_wdata_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;
  logic [7:0] rdata0_q, rdata0_d;
  logic [7:0] rdata1_q, rdata1_d;
  logic       elig0, elig1;

  // Arbitration, command capture on grant entry, and read-data capture at the end of a read grant
  always_comb begin
    state_d     = IDLE;
    rr_last_d   = rr_last_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;

    // A requester inside its own grant cycle is masked so one request yields one grant
    elig0 = req0 && (state_q != GNT0);
    elig1 = req1 && (state_q != GNT1);

    if (elig0 && elig1) begin
      state_d = rr_last_q ? GNT0 : GNT1;
    end else if (elig0) begin
      state_d = GNT0;
    end else if (elig1) begin
      state_d = GNT1;
    end

    case (state_d)
      GNT0: begin
        rr_last_d   = 1'b0;
        cmd_we_d    = we0;
        cmd_addr_d  = addr0;
        cmd_wdata_d = wdata0;
      end
      GNT1: begin
        rr_last_d   = 1'b1;
        cmd_we_d    = we1;
        cmd_addr_d  = addr1;
        cmd_wdata_d = wdata1;
      end
      default: ;
    endcase

    rvalid0_d = (state_q == GNT0) && !cmd_we_q;
    rvalid1_d = (state_q == GNT1) && !cmd_we_q;
    rdata0_d  = rvalid0_d ? rd1 : rdata0_q;
    rdata1_d  = rvalid1_d ? rd1 : rdata1_q;
  end

  // State, round-robin pointer, command and read-result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= 3'd0;
      cmd_wdata_q <= 8'h00;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= 8'h00;
      rdata1_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Outputs come straight from registers; the write enable is gated by the grant so reset kills it at once
  always_comb begin
    gnt0    = (state_q == GNT0);
    gnt1    = (state_q == GNT1);
    we3     = (state_q != IDLE) && cmd_we_q;
    wa3     = cmd_addr_q;
    wd3     = cmd_wdata_q;
    ra1     = cmd_addr_q;
    rvalid0 = rvalid0_q;
    rvalid1 = rvalid1_q;
    rdata0  = rdata0_q;
    rdata1  = rdata1_q;
  end

endmodule

// File: tb/tb_reg_arb.sv
// tb/tb_reg_arb.sv - directed self-checking bench for reg_arb with a register-file model
module tb_reg_arb;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       we0 = 1'b0, we1 = 1'b0;
  logic [2:0] addr0 = 3'd0, addr1 = 3'd0;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic       gnt0, gnt1, rvalid0, rvalid1, we3;
  logic [7:0] rdata0, rdata1, wd3, rd1;
  logic [2:0] wa3, ra1;

  logic [7:0] rf [8];
  logic       rf_load = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  reg_arb dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .wa3(wa3), .wd3(wd3), .we3(we3), .ra1(ra1), .rd1(rd1)
  );

  always #5 clk = ~clk;

  // Register file: preset to 8'h10+i, then written by the arbiter
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h10 + 8'(i);
    end else if (we3) begin
      rf[wa3] <= wd3;
    end
  end
  assign rd1 = rf[ra1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    rf_load = 1'b0;
    vectors++;
    if ({gnt0, gnt1, rvalid0, rvalid1, we3} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000", {gnt0, gnt1, rvalid0, rvalid1, we3});
    end
    vectors++;
    if ({rdata0, rdata1, wd3, wa3, ra1} !== 38'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", {rdata0, rdata1, wd3, wa3, ra1});
    end
    reset = 1'b1;
  endtask

  task automatic test_write();
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd3; wdata0 = 8'h5A;
    step();
    vectors++;
    if ({gnt0, gnt1, we3, wa3, wd3} !== {1'b1, 1'b0, 1'b1, 3'd3, 8'h5A}) begin
      miscompares++;
      $display("FAIL write_grant: got g0=%b g1=%b we3=%b wa3=%0d wd3=%h want 1 0 1 3 5a", gnt0, gnt1, we3, wa3, wd3);
    end
    req0 = 1'b0;
    step();
    vectors++;
    if ({gnt0, we3, rvalid0, wa3} !== {1'b0, 1'b0, 1'b0, 3'd3}) begin
      miscompares++;
      $display("FAIL write_after: got g0=%b we3=%b rv0=%b wa3=%0d want 0 0 0 3", gnt0, we3, rvalid0, wa3);
    end
    vectors++;
    if (rf[3] !== 8'h5A) begin
      miscompares++;
      $display("FAIL write_rf3: got %h want 5a", rf[3]);
    end
  endtask

  task automatic test_tie();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd3;
    step();
    vectors++;
    if ({gnt0, gnt1, we3, ra1} !== {1'b0, 1'b1, 1'b0, 3'd3}) begin
      miscompares++;
      $display("FAIL tie_first: got g0=%b g1=%b we3=%b ra1=%0d want 0 1 0 3", gnt0, gnt1, we3, ra1);
    end
    req1 = 1'b0;
    step();
    vectors++;
    if ({rvalid1, rdata1, gnt0, gnt1} !== {1'b1, 8'h5A, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL tie_rvalid1: got rv1=%b rd1=%h g0=%b g1=%b want 1 5a 1 0", rvalid1, rdata1, gnt0, gnt1);
    end
    req0 = 1'b0;
    step();
    vectors++;
    if ({rvalid0, rdata0, rvalid1, gnt0} !== {1'b1, 8'h11, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL tie_rvalid0: got rv0=%b rd0=%h rv1=%b g0=%b want 1 11 0 0", rvalid0, rdata0, rvalid1, gnt0);
    end
  endtask

  task automatic test_back_to_back();
    logic e1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd2;
    for (int k = 0; k < 6; k++) begin
      step();
      e1 = (k % 2 == 0);
      vectors++;
      if ({gnt0, gnt1} !== {~e1, e1}) begin
        miscompares++;
        $display("FAIL b2b_gnt[%0d]: got g0=%b g1=%b want %b %b", k, gnt0, gnt1, ~e1, e1);
      end
      if (k > 0) begin
        vectors++;
        if ({rvalid0, rvalid1} !== {e1, ~e1} || (e1 ? rdata0 : rdata1) !== (e1 ? 8'h10 : 8'h12)) begin
          miscompares++;
          $display("FAIL b2b_read[%0d]: got rv0=%b rv1=%b rd0=%h rd1=%h", k, rvalid0, rvalid1, rdata0, rdata1);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    vectors++;
    if ({gnt0, gnt1, rvalid0, rvalid1, rdata0} !== {4'b0010, 8'h10}) begin
      miscompares++;
      $display("FAIL b2b_end: got g0=%b g1=%b rv0=%b rv1=%b rd0=%h want 0 0 1 0 10", gnt0, gnt1, rvalid0, rvalid1, rdata0);
    end
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd7; wdata0 = 8'hC3;
    step();
    vectors++;
    if ({gnt0, we3, wa3, wd3} !== {1'b1, 1'b1, 3'd7, 8'hC3}) begin
      miscompares++;
      $display("FAIL wr_write: got g0=%b we3=%b wa3=%0d wd3=%h want 1 1 7 c3", gnt0, we3, wa3, wd3);
    end
    we0 = 1'b0;
    step();
    vectors++;
    if ({gnt0, we3} !== 2'b00) begin
      miscompares++;
      $display("FAIL wr_mask: got g0=%b we3=%b want 0 0", gnt0, we3);
    end
    step();
    vectors++;
    if ({gnt0, we3, ra1} !== {1'b1, 1'b0, 3'd7}) begin
      miscompares++;
      $display("FAIL wr_read: got g0=%b we3=%b ra1=%0d want 1 0 7", gnt0, we3, ra1);
    end
    req0 = 1'b0;
    step();
    vectors++;
    if ({rvalid0, rdata0} !== {1'b1, 8'hC3}) begin
      miscompares++;
      $display("FAIL wr_rdata: got rv0=%b rd0=%h want 1 c3", rvalid0, rdata0);
    end
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd2; wdata0 = 8'hFF;
    step();
    vectors++;
    if ({gnt0, we3, wa3} !== {1'b1, 1'b1, 3'd2}) begin
      miscompares++;
      $display("FAIL rmid_grant: got g0=%b we3=%b wa3=%0d want 1 1 2", gnt0, we3, wa3);
    end
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if ({gnt0, gnt1, rvalid0, rvalid1, we3, rdata0, rdata1, wd3, wa3, ra1} !== 43'h0) begin
      miscompares++;
      $display("FAIL rmid_async: got g0=%b we3=%b rd0=%h rd1=%h wd3=%h wa3=%0d ra1=%0d want all 0", gnt0, we3, rdata0, rdata1, wd3, wa3, ra1);
    end
    req0 = 1'b0;
    step();
    vectors++;
    if (rf[2] !== 8'h12) begin
      miscompares++;
      $display("FAIL rmid_rf2: got %h want 12", rf[2]);
    end
    reset = 1'b1;
    step();
    vectors++;
    if ({gnt0, rvalid0, we3} !== 3'b000) begin
      miscompares++;
      $display("FAIL rmid_after: got g0=%b rv0=%b we3=%b want 0 0 0", gnt0, rvalid0, we3);
    end
  endtask

  task automatic test_withdraw();
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd4;
    step();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin
      miscompares++;
      $display("FAIL wd_gnt0: got g0=%b g1=%b want 1 0", gnt0, gnt1);
    end
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd5;
    #2;
    req1 = 1'b0;
    step();
    vectors++;
    if ({gnt1, rvalid0, rdata0} !== {1'b0, 1'b1, 8'h14}) begin
      miscompares++;
      $display("FAIL wd_nogrant: got g1=%b rv0=%b rd0=%h want 0 1 14", gnt1, rvalid0, rdata0);
    end
    step();
    vectors++;
    if ({gnt1, rvalid1} !== 2'b00) begin
      miscompares++;
      $display("FAIL wd_norvalid: got g1=%b rv1=%b want 0 0", gnt1, rvalid1);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_tie();
    test_back_to_back();
    test_write_read();
    test_reset_mid();
    test_withdraw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_arb.md
REG_ARB -- requirements
Module: reg_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and reset.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 req0, req1  input  1 each  request from requester 0 / 1; held high with its command until the matching gnt is seen.
REQ-005 we0, we1  input  1 each  command type: 1 = write, 0 = read.
REQ-006 addr0, addr1  input  3 each  register address 0..7.
REQ-007 wdata0, wdata1  input  8 each  write data; ignored for reads.
REQ-008 gnt0, gnt1  output  1 each  registered one-cycle grant pulse; command executes in this cycle.
REQ-009 rvalid0, rvalid1  output  1 each  one-cycle pulse; rdata holds read result.
REQ-010 rdata0, rdata1  output  8 each  registered read data; holds last value between pulses.
REQ-011 wa3  output  3  register-file write address.
REQ-012 wd3  output  8  register-file write data.
REQ-013 we3  output  1  register-file write enable.
REQ-014 ra1  output  3  register-file read address.
REQ-015 rd1  input  8  register-file read data, combinational from ra1.

Function
REQ-016 FSM states SHALL be IDLE, GNT0 and GNT1; gnt0 = (state==GNT0), gnt1 = (state==GNT1).
REQ-017 Eligible request: reqN=1 and state != GNTN; a requester in its grant cycle is masked, so one req assertion yields exactly one grant.
REQ-018 Next state: no eligible request -> IDLE; one eligible -> its GNT state; both eligible -> requester other than rr_last.
REQ-019 rr_last (1 bit) SHALL update to N on every edge entering GNTN; reset value 0, so requester 1 wins the first tie.
REQ-020 On the edge entering GNTN, the block SHALL capture weN, addrN, wdataN into a command register that drives the register-file ports during GNTN.
REQ-021 Write in GNTN: we3=1, wa3=addr, wd3=wdata; write commits at the closing edge; no rvalid.
REQ-022 Read in GNTN: we3=0, ra1=addr; at the closing edge rd1 is captured into rdataN and rvalidN=1 for the next cycle.
REQ-023 Latency: req high in cycle T -> gnt in T+1 (if selected) -> read data/rvalid in T+2.
REQ-024 Back-to-back: GNT0 -> GNT1 -> GNT0 SHALL be possible with no IDLE cycle when both keep requesting.
REQ-025 Outside grant cycles: we3=0; wa3, wd3, ra1 hold the last command value.
REQ-026 Write then read of the same address on consecutive grants SHALL return the new value (write commits before the read cycle).
REQ-027 Max wait for a continuously requesting requester: 2 cycles after req rises.
REQ-028 Deassertion of reqN before gntN SHALL withdraw the request; no grant for it.

Reset
REQ-029 While reset=0: state=IDLE, rr_last=0, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=8'h00, we3=0, wa3=0, wd3=8'h00, ra1=0.
REQ-030 Reset asserted mid-grant SHALL abort the command; we3 drops asynchronously; no rvalid follows.
REQ-031 First grant possible on the first rising edge after reset returns to 1.

Verification
REQ-032 req0 write addr=3 data=8'h5A, req1 idle -> gnt0 next cycle, we3=1, wa3=3, wd3=8'h5A; rf reg3=8'h5A.
REQ-033 Both req at once after reset, req1 read addr=3 -> gnt1 first, rvalid1 two cycles after req with rdata1=8'h5A; then gnt0.
REQ-034 Both held continuously for 6 cycles -> grants alternate 1,0,1,0,... with no IDLE gap.
REQ-035 req0 write addr=7 data=8'hC3 then immediate req0 read addr=7 -> rvalid0 with rdata0=8'hC3.
REQ-036 reset pulsed low during GNT0 write addr=2 data=8'hFF -> we3=0 at once, all outputs at reset values, rf reg2 unchanged.
REQ-037 req1 raised then dropped before gnt (while gnt0 active) -> no gnt1, no rvalid1.
